// File: rtl/ad9361_rx_framer_pkg.sv
// Shared constants for the AD9361 RX framer: slot indices, words per frame,
// default word width and the framer state encoding.
package ad9361_pkg;

  localparam int WIDTH_DEFAULT = 12;
  localparam int SISO_WORDS    = 2;
  localparam int MIMO_WORDS    = 4;

  localparam logic [1:0] SLOT_S0 = 2'd0;
  localparam logic [1:0] SLOT_S1 = 2'd1;
  localparam logic [1:0] SLOT_S2 = 2'd2;
  localparam logic [1:0] SLOT_S3 = 2'd3;

  // Low two bits of an active state are the slot index; bit 2 marks IDLE.
  typedef enum logic [2:0] {
    ST_S0   = 3'b000,
    ST_S1   = 3'b001,
    ST_S2   = 3'b010,
    ST_S3   = 3'b011,
    ST_IDLE = 3'b100
  } state_t;

endpackage

// File: rtl/ad9361_rx_framer_if.sv
// Parallel I/Q sample handshake feeding the framer.
interface ad9361_rx_framer_if
  import ad9361_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] in_i0;
  logic [WIDTH-1:0] in_q0;
  logic [WIDTH-1:0] in_i1;
  logic [WIDTH-1:0] in_q1;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_i0, in_q0, in_i1, in_q1, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_i0, in_q0, in_i1, in_q1, in_valid,
    output in_ready
  );
endinterface

// File: rtl/ad9361_rx_framer.sv
// AD9361-side RX sample source: takes one parallel I/Q sample per frame and
// serialises it onto a 12-bit word bus with a frame strobe, SISO or MIMO order.
// MIMO sends channel 1 first to match the B210 channel swap.
module ad9361_rx_framer
  import ad9361_pkg::*;
#(
  parameter int WIDTH             = WIDTH_DEFAULT,
  parameter bit ZERO_ON_UNDERFLOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mimo,
  ad9361_rx_framer_if.slave smp,
  output logic             rx_frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             underflow,
  output logic             active
);

  state_t           state;
  logic             mimo_l;
  logic [WIDTH-1:0] hold_i0;
  logic [WIDTH-1:0] hold_q0;
  logic [WIDTH-1:0] hold_i1;
  logic [WIDTH-1:0] hold_q1;

  logic [1:0]       slot;
  logic [1:0]       slot_nxt;
  logic [1:0]       last_slot;
  logic             boundary;
  logic             ready;

  // Word carried by a given slot of the latched mode.
  function automatic logic [WIDTH-1:0] slot_word(
    input logic             m,
    input logic [1:0]       s,
    input logic [WIDTH-1:0] i0,
    input logic [WIDTH-1:0] q0,
    input logic [WIDTH-1:0] i1,
    input logic [WIDTH-1:0] q1
  );
    logic [WIDTH-1:0] w;
    if (m) begin
      case (s)
        SLOT_S0: w = i1;
        SLOT_S1: w = q1;
        SLOT_S2: w = i0;
        default: w = q0;
      endcase
    end else begin
      w = (s == SLOT_S0) ? i0 : q0;
    end
    return w;
  endfunction

  // Frame strobe level for a given slot: first half of the frame is high.
  function automatic logic slot_frame(input logic m, input logic [1:0] s);
    return m ? ((s == SLOT_S0) || (s == SLOT_S1)) : (s == SLOT_S0);
  endfunction

  assign slot      = state[1:0];
  assign slot_nxt  = slot + 2'd1;
  assign last_slot = mimo_l ? 2'(MIMO_WORDS - 1) : 2'(SISO_WORDS - 1);
  assign boundary  = (state == ST_IDLE) || (slot == last_slot);
  assign ready     = reset_n && enable && boundary;
  assign smp.in_ready = ready;
  assign active    = (state != ST_IDLE);

  // Frame sequencer: accept at boundaries, zero-fill or idle otherwise,
  // and step through the slots with registered word and strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mimo_l    <= 1'b0;
      hold_i0   <= '0;
      hold_q0   <= '0;
      hold_i1   <= '0;
      hold_q1   <= '0;
      rx_frame  <= 1'b0;
      rx_data   <= '0;
      underflow <= 1'b0;
    end else if (boundary) begin
      if (enable && smp.in_valid) begin
        state     <= ST_S0;
        mimo_l    <= mimo;
        hold_i0   <= smp.in_i0;
        hold_q0   <= smp.in_q0;
        hold_i1   <= smp.in_i1;
        hold_q1   <= smp.in_q1;
        rx_data   <= slot_word(mimo, SLOT_S0, smp.in_i0, smp.in_q0,
                               smp.in_i1, smp.in_q1);
        rx_frame  <= 1'b1;
        underflow <= 1'b0;
      end else if (enable && ZERO_ON_UNDERFLOW && (state != ST_IDLE)) begin
        // Keep the strobe cadence in the previously latched mode, all zeros.
        state     <= ST_S0;
        hold_i0   <= '0;
        hold_q0   <= '0;
        hold_i1   <= '0;
        hold_q1   <= '0;
        rx_data   <= '0;
        rx_frame  <= 1'b1;
        underflow <= 1'b1;
      end else begin
        state     <= ST_IDLE;
        rx_data   <= '0;
        rx_frame  <= 1'b0;
        underflow <= 1'b0;
      end
    end else begin
      state     <= state_t'({1'b0, slot_nxt});
      rx_data   <= slot_word(mimo_l, slot_nxt, hold_i0, hold_q0, hold_i1, hold_q1);
      rx_frame  <= slot_frame(mimo_l, slot_nxt);
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad9361_rx_framer.sv
// Directed bench for ad9361_rx_framer: SISO/MIMO bursts, mode switch,
// underflow zero-fill, enable drop and asynchronous reset mid-frame.
module tb_ad9361_rx_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mimo = 1'b0;
  logic        rx_frame;
  logic [11:0] rx_data;
  logic        underflow;
  logic        active;

  int checks = 0;
  int errors = 0;

  ad9361_rx_framer_if #(.WIDTH(12)) smp ();

  ad9361_rx_framer #(.WIDTH(12), .ZERO_ON_UNDERFLOW(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .mimo      (mimo),
    .smp       (smp),
    .rx_frame  (rx_frame),
    .rx_data   (rx_data),
    .underflow (underflow),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one word and check the registered outputs of the new cycle.
  task automatic step(input string tag, input logic [11:0] d, input logic f,
                      input logic u, input logic a);
    tick();
    chk({tag, ".data"},  32'(rx_data),   32'(d));
    chk({tag, ".frame"}, 32'(rx_frame),  32'(f));
    chk({tag, ".uflow"}, 32'(underflow), 32'(u));
    chk({tag, ".active"}, 32'(active),   32'(a));
  endtask

  task automatic sample(input logic [11:0] i0, input logic [11:0] q0,
                        input logic [11:0] i1, input logic [11:0] q1);
    smp.in_i0 = i0;
    smp.in_q0 = q0;
    smp.in_i1 = i1;
    smp.in_q1 = q1;
  endtask

  initial begin
    smp.in_valid = 1'b0;
    sample(12'h0, 12'h0, 12'h0, 12'h0);

    // Reset state, in_ready held low while in reset even with enable high
    tick();
    enable = 1'b1;
    tick();
    chk("rst.frame", 32'(rx_frame), 32'd0);
    chk("rst.data",  32'(rx_data),  32'd0);
    chk("rst.active", 32'(active),  32'd0);
    chk("rst.uflow", 32'(underflow), 32'd0);
    chk("rst.ready", 32'(smp.in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("idle.ready", 32'(smp.in_ready), 32'd1);

    // SISO burst of three samples
    mimo = 1'b0;
    smp.in_valid = 1'b1;
    sample(12'hA00, 12'hB00, 12'h0, 12'h0);
    step("siso0i", 12'hA00, 1'b1, 1'b0, 1'b1);
    chk("siso.s0.ready", 32'(smp.in_ready), 32'd0);
    sample(12'hA01, 12'hB01, 12'h0, 12'h0);
    step("siso0q", 12'hB00, 1'b0, 1'b0, 1'b1);
    chk("siso.s1.ready", 32'(smp.in_ready), 32'd1);
    step("siso1i", 12'hA01, 1'b1, 1'b0, 1'b1);
    sample(12'hA02, 12'hB02, 12'h0, 12'h0);
    step("siso1q", 12'hB01, 1'b0, 1'b0, 1'b1);
    step("siso2i", 12'hA02, 1'b1, 1'b0, 1'b1);

    // Mode switch mid SISO frame, then MIMO burst with no idle slot
    mimo = 1'b1;
    sample(12'hA00, 12'hB00, 12'hC00, 12'hD00);
    step("siso2q", 12'hB02, 1'b0, 1'b0, 1'b1);
    step("mimo0i1", 12'hC00, 1'b1, 1'b0, 1'b1);
    sample(12'hA01, 12'hB01, 12'hC01, 12'hD01);
    step("mimo0q1", 12'hD00, 1'b1, 1'b0, 1'b1);
    step("mimo0i0", 12'hA00, 1'b0, 1'b0, 1'b1);
    step("mimo0q0", 12'hB00, 1'b0, 1'b0, 1'b1);
    step("mimo1i1", 12'hC01, 1'b1, 1'b0, 1'b1);
    step("mimo1q1", 12'hD01, 1'b1, 1'b0, 1'b1);

    // Enable drop in S1 of a MIMO frame: S2/S3 still complete
    enable = 1'b0;
    step("mimo1i0", 12'hA01, 1'b0, 1'b0, 1'b1);
    step("mimo1q0", 12'hB01, 1'b0, 1'b0, 1'b1);
    chk("endrop.s3.ready", 32'(smp.in_ready), 32'd0);
    step("endrop.idle", 12'h000, 1'b0, 1'b0, 1'b0);
    chk("endrop.ready", 32'(smp.in_ready), 32'd0);

    // Underflow: one sample, missed boundary, then another sample
    enable = 1'b1;
    mimo = 1'b0;
    sample(12'hA00, 12'hB00, 12'h0, 12'h0);
    step("uf.i0", 12'hA00, 1'b1, 1'b0, 1'b1);
    smp.in_valid = 1'b0;
    step("uf.q0", 12'hB00, 1'b0, 1'b0, 1'b1);
    step("uf.zi", 12'h000, 1'b1, 1'b1, 1'b1);
    smp.in_valid = 1'b1;
    sample(12'hA01, 12'hB01, 12'h0, 12'h0);
    step("uf.zq", 12'h000, 1'b0, 1'b0, 1'b1);
    step("uf.i1", 12'hA01, 1'b1, 1'b0, 1'b1);
    enable = 1'b0;
    step("uf.q1", 12'hB01, 1'b0, 1'b0, 1'b1);
    step("uf.idle", 12'h000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during S2 of a MIMO frame
    enable = 1'b1;
    mimo = 1'b1;
    sample(12'hA05, 12'hB05, 12'hC05, 12'hD05);
    step("ar.i1", 12'hC05, 1'b1, 1'b0, 1'b1);
    smp.in_valid = 1'b0;
    step("ar.q1", 12'hD05, 1'b1, 1'b0, 1'b1);
    step("ar.i0", 12'hA05, 1'b0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar.frame", 32'(rx_frame), 32'd0);
    chk("ar.data",  32'(rx_data),  32'd0);
    chk("ar.active", 32'(active),  32'd0);
    chk("ar.ready", 32'(smp.in_ready), 32'd0);
    #2;
    reset_n = 1'b1;
    smp.in_valid = 1'b1;
    sample(12'hA06, 12'hB06, 12'hC06, 12'hD06);
    step("post.i1", 12'hC06, 1'b1, 1'b0, 1'b1);
    smp.in_valid = 1'b0;
    enable = 1'b0;
    step("post.q1", 12'hD06, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
